// File: rtl/fir_mac_sequencer_if.sv
// Sample, result, coefficient-write and status signals of fir_mac_sequencer.
// The slave modport is the engine side; master is the producer/consumer side.
interface fir_mac_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int TAPS        = 4,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
);
  localparam int AW = $clog2(TAPS);

  logic                          s_valid;
  logic                          s_ready;
  logic signed [DATA_WIDTH-1:0]  s_data;
  logic                          coef_we;
  logic [AW-1:0]                 coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          coef_wr_drop;
  logic                          m_valid;
  logic                          m_ready;
  logic signed [ACC_WIDTH-1:0]   m_data;
  logic                          busy;

  modport slave (
    input  s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
    output s_ready, coef_wr_drop, m_valid, m_data, busy
  );

  modport master (
    output s_valid, s_data, coef_we, coef_addr, coef_data, m_ready,
    input  s_ready, coef_wr_drop, m_valid, m_data, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR engine: one shared multiply-accumulate unit is stepped
// across a TAPS-deep delay line, one tap per clock, for every accepted sample.
module fir_mac_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int TAPS        = 4,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 2
) (
  input  logic               clk,
  input  logic               rst,
  fir_mac_sequencer_if.slave io_bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
  localparam logic [AW:0] TAP_COUNT = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        r_state;
  state_t                        w_stateNext;
  logic signed [DATA_WIDTH-1:0]  r_x [TAPS];
  logic signed [COEFF_WIDTH-1:0] r_h [TAPS];
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [AW-1:0]                 r_tap;
  logic                          r_busy;
  logic                          r_coefWrDrop;
  logic                          w_sReady;
  logic                          w_mValid;
  logic                          w_sAccept;
  logic                          w_coefWrOk;
  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prodExt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_sReady    = 1'b0;
    w_mValid    = 1'b0;
    case (r_state)
      IDLE: begin
        w_sReady = ~rst;
        if (io_bus.s_valid && w_sReady) w_stateNext = MAC;
      end
      MAC: begin
        if (r_tap == TAP_LAST) w_stateNext = OUT;
      end
      OUT: begin
        w_mValid = 1'b1;
        if (io_bus.m_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_sAccept  = w_sReady & io_bus.s_valid;
  // Writes only land while idle, so a running MAC always sees one coefficient set
  assign w_coefWrOk = io_bus.coef_we & (r_state == IDLE) & ({1'b0, io_bus.coef_addr} < TAP_COUNT);

  // Full-precision signed product, then sign-extended (or wrapped) to the accumulator width
  assign w_prod = PW'(r_x[r_tap]) * PW'(r_h[r_tap]);

  generate
    if (ACC_WIDTH > PW) begin : g_extend
      assign w_prodExt = {{(ACC_WIDTH - PW){w_prod[PW-1]}}, w_prod};
    end else if (ACC_WIDTH == PW) begin : g_equal
      assign w_prodExt = w_prod;
    end else begin : g_wrap
      assign w_prodExt = w_prod[ACC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_tap        <= '0;
      r_busy       <= 1'b0;
      r_coefWrDrop <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_h[i] <= '0;
      end
    end else begin
      r_busy       <= (w_stateNext != IDLE);
      r_coefWrDrop <= io_bus.coef_we & ~w_coefWrOk;
      if (w_coefWrOk) r_h[io_bus.coef_addr] <= io_bus.coef_data;
      if (w_sAccept) begin
        for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
        r_x[0] <= io_bus.s_data;
        r_acc  <= '0;
        r_tap  <= '0;
      end else if (r_state == MAC) begin
        r_acc <= r_acc + w_prodExt;
        r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + 1'b1;
      end
    end
  end

  assign io_bus.s_ready      = w_sReady;
  assign io_bus.m_valid      = w_mValid;
  assign io_bus.m_data       = r_acc;
  assign io_bus.busy         = r_busy;
  assign io_bus.coef_wr_drop = r_coefWrDrop;
endmodule
